db9md_pad_scanner: RTL and testbench



---
 rtl/db9md_pad_scanner_if.sv | 44 ++++
 rtl/db9md_pad_scanner.sv | 219 +++++++++++++++++++++
 tb/tb_db9md_pad_scanner.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/db9md_pad_scanner_if.sv
// rtl/db9md_pad_scanner_if.sv - pad bus and decoded-output bundle for the DB9 MD pad scanner
//
// Purpose : groups the shared DB9 pin bus, the select/split drive lines and
//           the decoded joystick outputs into one interface.
// Signals : joy_in[5:0]     active-low pad pins (driven by the pads)
//           joy_mdsel       MD select line (pin 7)
//           joy_split       0 = pad 1 on the bus, 1 = pad 2
//           joystick1/2     decoded active-high words
//           pad_type1/2     00 none/Atari, 01 3-button, 10 6-button
//           scan_done       one-cycle pulse after both pads are committed
// Modports: master = scanner side, slave = pad/consumer side.

interface db9md_pad_scanner_if;
  logic [5:0]  joy_in;
  logic        joy_mdsel;
  logic        joy_split;
  logic [15:0] joystick1;
  logic [15:0] joystick2;
  logic [1:0]  pad_type1;
  logic [1:0]  pad_type2;
  logic        scan_done;

  modport master (
    input  joy_in,
    output joy_mdsel,
    output joy_split,
    output joystick1,
    output joystick2,
    output pad_type1,
    output pad_type2,
    output scan_done
  );

  modport slave (
    output joy_in,
    input  joy_mdsel,
    input  joy_split,
    input  joystick1,
    input  joystick2,
    input  pad_type1,
    input  pad_type2,
    input  scan_done
  );
endinterface

// File: rtl/db9md_pad_scanner.sv
// rtl/db9md_pad_scanner.sv - polls two DB9 Mega Drive / Atari pads sharing one pin bus
//
// Purpose : walks the MD 6-button select protocol on each pad in turn
//           (IDLE -> SCAN pad 1 -> SWAP -> SCAN pad 2 -> IDLE), decodes the
//           active-low pin samples and commits one 16-bit word plus pad type
//           per pad at the end of its scan.
// Ports   : clk      system clock
//           reset_n  asynchronous active-low reset
//           bus      db9md_pad_scanner_if.master (joy_in in; joy_mdsel,
//                    joy_split, joystick1/2, pad_type1/2, scan_done out)
// Params  : PHASE_CYC cycles per select phase, SWAP_CYC settle cycles after
//           switching pads, IDLE_CYC quiet cycles between full scans.
// Option  : DB9MD_DEBOUNCE_EN - outputs only change when two consecutive
//           scans of a pad decode identically.

module db9md_pad_scanner #(
  parameter int PHASE_CYC = 480,
  parameter int SWAP_CYC  = 480,
  parameter int IDLE_CYC  = 96000
) (
  input  logic clk,
  input  logic reset_n,
  db9md_pad_scanner_if.master bus
);

  localparam int MAX_AB = (IDLE_CYC > SWAP_CYC) ? IDLE_CYC : SWAP_CYC;
  localparam int MAXC   = (MAX_AB > PHASE_CYC) ? MAX_AB : PHASE_CYC;
  localparam int CW     = (MAXC > 2) ? $clog2(MAXC) : 1;

  localparam logic [CW-1:0] IDLE_LAST  = CW'(IDLE_CYC - 1);
  localparam logic [CW-1:0] SWAP_LAST  = CW'(SWAP_CYC - 1);
  localparam logic [CW-1:0] PHASE_LAST = CW'(PHASE_CYC - 1);
  localparam logic [CW-1:0] CNT_ONE    = {{(CW-1){1'b0}}, 1'b1};

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SCAN = 2'd1;
  localparam logic [1:0] S_SWAP = 2'd2;

  logic [1:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_phase;
  logic          r_mdsel;
  logic          r_split;
  logic          r_scan_done;
  logic [15:0]   r_word1;
  logic [15:0]   r_word2;
  logic [1:0]    r_type1;
  logic [1:0]    r_type2;

  // Shadow samples; only the pins each phase contributes are kept.
  logic [5:0]    r_s0;   // p=0 high: all six pins
  logic [3:0]    r_s1;   // p=1 low : {pin9, pin6, right, left}
  logic [3:0]    r_s5;   // p=5 low : directions (6-button signature)
  logic [3:0]    r_s6;   // p=6 high: {Mode, X, Y, Z} on direction pins

`ifdef DB9MD_DEBOUNCE_EN
  logic [15:0]   r_prev_word1;
  logic [15:0]   r_prev_word2;
  logic [1:0]    r_prev_type1;
  logic [1:0]    r_prev_type2;
`endif

  logic          w_md;
  logic          w_six;
  logic [15:0]   w_md_word;
  logic [15:0]   w_atari_word;
  logic [15:0]   w_word;
  logic [1:0]    w_type;
  logic          w_phase_end;

  // MD pads ground left and right while select is low; Atari sticks cannot.
  assign w_md  = ~r_s1[0] & ~r_s1[1];
  // Third low phase of a 6-button pad grounds all four direction pins.
  assign w_six = w_md & (r_s5 == 4'b0000);

  assign w_md_word = {4'b0000,
                      ~r_s6[3], ~r_s6[0], ~r_s6[1], ~r_s6[2],   // Mode Z Y X
                      ~r_s1[3], ~r_s0[5], ~r_s0[4], ~r_s1[2],   // Start C B A
                      ~r_s0[0], ~r_s0[1], ~r_s0[2], ~r_s0[3]};  // up down left right

  assign w_atari_word = {10'b0, ~r_s0[5], ~r_s0[4],
                         ~r_s0[0], ~r_s0[1], ~r_s0[2], ~r_s0[3]};

  always_comb begin
    w_word = w_atari_word;
    w_type = 2'b00;
    if (w_md && !w_six) begin
      w_word = {8'h00, w_md_word[7:0]};
      w_type = 2'b01;
    end else if (w_six) begin
      w_word = w_md_word;
      w_type = 2'b10;
    end
  end

  assign w_phase_end = (r_cnt == PHASE_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_phase     <= 3'd0;
      r_mdsel     <= 1'b1;
      r_split     <= 1'b0;
      r_scan_done <= 1'b0;
      r_word1     <= 16'h0000;
      r_word2     <= 16'h0000;
      r_type1     <= 2'b00;
      r_type2     <= 2'b00;
      r_s0        <= '1;
      r_s1        <= '1;
      r_s5        <= '1;
      r_s6        <= '1;
`ifdef DB9MD_DEBOUNCE_EN
      r_prev_word1 <= 16'h0000;
      r_prev_word2 <= 16'h0000;
      r_prev_type1 <= 2'b00;
      r_prev_type2 <= 2'b00;
`endif
    end else begin
      r_scan_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (r_cnt == IDLE_LAST) begin
            r_cnt   <= '0;
            r_phase <= 3'd0;
            r_split <= 1'b0;
            r_mdsel <= 1'b1;
            r_state <= S_SCAN;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end

        S_SCAN: begin
          if (w_phase_end) begin
            r_cnt <= '0;
            case (r_phase)
              3'd0:    r_s0 <= bus.joy_in;
              3'd1:    r_s1 <= bus.joy_in[5:2];
              3'd5:    r_s5 <= bus.joy_in[3:0];
              3'd6:    r_s6 <= bus.joy_in[3:0];
              default: ;
            endcase
            if (r_phase == 3'd7) begin
              // End of this pad's scan: commit word and type together.
              r_phase <= 3'd0;
              r_mdsel <= 1'b1;
              if (!r_split) begin
`ifdef DB9MD_DEBOUNCE_EN
                if (w_word == r_prev_word1 && w_type == r_prev_type1) begin
                  r_word1 <= w_word;
                  r_type1 <= w_type;
                end
                r_prev_word1 <= w_word;
                r_prev_type1 <= w_type;
`else
                r_word1 <= w_word;
                r_type1 <= w_type;
`endif
                r_split <= 1'b1;
                r_state <= S_SWAP;
              end else begin
`ifdef DB9MD_DEBOUNCE_EN
                if (w_word == r_prev_word2 && w_type == r_prev_type2) begin
                  r_word2 <= w_word;
                  r_type2 <= w_type;
                end
                r_prev_word2 <= w_word;
                r_prev_type2 <= w_type;
`else
                r_word2 <= w_word;
                r_type2 <= w_type;
`endif
                r_split     <= 1'b0;
                r_scan_done <= 1'b1;
                r_state     <= S_IDLE;
              end
            end else begin
              r_phase <= r_phase + 3'd1;
              // Next phase p+1 drives ~(p+1)[0], which equals p[0].
              r_mdsel <= r_phase[0];
            end
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end

        S_SWAP: begin
          if (r_cnt == SWAP_LAST) begin
            r_cnt   <= '0;
            r_phase <= 3'd0;
            r_mdsel <= 1'b1;
            r_state <= S_SCAN;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
          r_phase <= 3'd0;
          r_mdsel <= 1'b1;
          r_split <= 1'b0;
        end
      endcase
    end
  end

  assign bus.joy_mdsel = r_mdsel;
  assign bus.joy_split = r_split;
  assign bus.joystick1 = r_word1;
  assign bus.joystick2 = r_word2;
  assign bus.pad_type1 = r_type1;
  assign bus.pad_type2 = r_type2;
  assign bus.scan_done = r_scan_done;

endmodule

// File: tb/tb_db9md_pad_scanner.sv
// tb/tb_db9md_pad_scanner.sv - self-checking bench for db9md_pad_scanner with pad models

module tb_db9md_pad_scanner;
  localparam int PH     = 8;
  localparam int SW     = 8;
  localparam int ID     = 40;
  localparam int PERIOD = ID + SW + 16 * PH;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  db9md_pad_scanner_if bus();

  db9md_pad_scanner #(
    .PHASE_CYC(PH),
    .SWAP_CYC (SW),
    .IDLE_CYC (ID)
  ) dut (
    .clk    (clk),
    .reset_n(rst_n),
    .bus    (bus)
  );

  typedef struct {
    logic [15:0] w1;
    logic [1:0]  t1;
    logic [15:0] w2;
    logic [1:0]  t2;
  } exp_t;
  exp_t q[$];

  // Pad kinds: 0 unplugged, 1 Atari, 2 3-button, 3 6-button.
  int          typ1 = 0, typ2 = 0;
  logic [11:0] btn1 = '0, btn2 = '0;
  bit          noisy1 = 0;
  int          k = 0, hicnt = 0, n_tog = 0, cyc = 0;
  logic        prev_sel = 1'b1, prev_split = 1'b0;
  int          n_chk = 0, n_pass = 0;

  logic [15:0] pw1, pw2, ow1, ow2;
  logic [1:0]  pt1, pt2, ot1, ot2;

  function automatic logic [5:0] pins(int t, logic [11:0] b, logic sel, int kk, bit noisy);
    logic [5:0] p;
    p = 6'h3F;
    case (t)
      1: p = ~{b[5], b[4], b[0], b[1], b[2], b[3]};
      2, 3: begin
        if (t == 3 && kk == 3) begin
          if (sel) p = ~{b[6], b[5], b[11], b[8], b[9], b[10]};
          else     p = ~{b[7], b[4], 4'hF};
        end else if (sel) begin
          p = ~{b[6], b[5], b[0], b[1], b[2], b[3]};
          if (noisy && kk == 3) p[3:0] = 4'h0;
        end else begin
          p = ~{b[7], b[4], 2'b11, b[2], b[3]};
        end
      end
      default: p = 6'h3F;
    endcase
    return p;
  endfunction

  always_comb begin
    bus.joy_in = bus.joy_split ? pins(typ2, btn2, bus.joy_mdsel, k, 1'b0)
                               : pins(typ1, btn1, bus.joy_mdsel, k, noisy1);
  end

  // Select-edge counter inside the pads; cleared by a long high or a bus swap.
  always @(negedge clk) begin
    int nk, nh;
    nk = k;
    nh = hicnt;
    if (prev_sel && !bus.joy_mdsel) nk = nk + 1;
    if (bus.joy_mdsel) nh = nh + 1; else nh = 0;
    if (nh >= 20) nk = 0;
    if (bus.joy_split !== prev_split) nk = 0;
    if (bus.joy_mdsel !== prev_sel) n_tog <= n_tog + 1;
    k          <= nk;
    hicnt      <= nh;
    prev_sel   <= bus.joy_mdsel;
    prev_split <= bus.joy_split;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic dec(int t, logic [11:0] b, output logic [15:0] w, output logic [1:0] ty);
    case (t)
      1:       begin w = {10'b0, b[5:0]}; ty = 2'b00; end
      2:       begin w = {8'b0, b[7:0]};  ty = 2'b01; end
      3:       begin w = {4'b0, b};       ty = 2'b10; end
      default: begin w = 16'h0;           ty = 2'b00; end
    endcase
  endtask

  task automatic reset_model();
    pw1 = '0; pw2 = '0; ow1 = '0; ow2 = '0;
    pt1 = '0; pt2 = '0; ot1 = '0; ot2 = '0;
  endtask

  task automatic push_exp();
    logic [15:0] w;
    logic [1:0]  t;
    exp_t e;
    dec(typ1, btn1, w, t);
`ifdef DB9MD_DEBOUNCE_EN
    if (w == pw1 && t == pt1) begin ow1 = w; ot1 = t; end
    pw1 = w; pt1 = t;
`else
    ow1 = w; ot1 = t;
`endif
    dec(typ2, btn2, w, t);
`ifdef DB9MD_DEBOUNCE_EN
    if (w == pw2 && t == pt2) begin ow2 = w; ot2 = t; end
    pw2 = w; pt2 = t;
`else
    ow2 = w; ot2 = t;
`endif
    e.w1 = ow1; e.t1 = ot1; e.w2 = ow2; e.t2 = ot2;
    q.push_back(e);
  endtask

  task automatic run_scan(string tag, bit timing);
    int   c0, t0;
    bit   got;
    exp_t e;
    c0  = cyc;
    t0  = n_tog;
    got = 0;
    for (int i = 0; i < 2 * PERIOD && !got; i++) begin
      @(negedge clk);
      #1;
      if (bus.scan_done === 1'b1) got = 1;
    end
    chk({tag, "_done"}, 32'(got), 32'd1);
    if (got) begin
      chk({tag, "_qsize"}, 32'(q.size()), 32'd1);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk({tag, "_joy1"}, 32'(bus.joystick1), 32'(e.w1));
        chk({tag, "_type1"}, 32'(bus.pad_type1), 32'(e.t1));
        chk({tag, "_joy2"}, 32'(bus.joystick2), 32'(e.w2));
        chk({tag, "_type2"}, 32'(bus.pad_type2), 32'(e.t2));
      end
      if (timing) begin
        chk({tag, "_period"}, 32'(cyc - c0), 32'(PERIOD));
        chk({tag, "_toggles"}, 32'(n_tog - t0), 32'd16);
      end
      @(negedge clk);
      #1;
      chk({tag, "_pulse"}, 32'(bus.scan_done), 32'd0);
    end
  endtask

  initial begin
    bit seen;
    reset_model();
    repeat (3) @(negedge clk);
    #1;
    chk("rst_joy1", 32'(bus.joystick1), 32'h0);
    chk("rst_joy2", 32'(bus.joystick2), 32'h0);
    chk("rst_type1", 32'(bus.pad_type1), 32'h0);
    chk("rst_type2", 32'(bus.pad_type2), 32'h0);
    chk("rst_mdsel", 32'(bus.joy_mdsel), 32'h1);
    chk("rst_split", 32'(bus.joy_split), 32'h0);
    chk("rst_done", 32'(bus.scan_done), 32'h0);
    rst_n = 1'b1;

    push_exp();
    run_scan("nopad", 1'b1);

    typ1 = 3; btn1 = 12'h818; typ2 = 2; btn2 = 12'h081;
    push_exp(); run_scan("six_three", 1'b0);

    typ1 = 2; btn1 = 12'h040; noisy1 = 1; typ2 = 1; btn2 = 12'h012;
    push_exp(); run_scan("three_c_a", 1'b0);
    push_exp(); run_scan("three_c_b", 1'b0);

    typ1 = 3; btn1 = 12'h700; noisy1 = 0;
    push_exp(); run_scan("glitch", 1'b0);
    typ1 = 2; btn1 = 12'h040; noisy1 = 1;
    push_exp(); run_scan("back_a", 1'b0);
    push_exp(); run_scan("back_b", 1'b0);

    typ1 = 0; typ2 = 0; noisy1 = 0;
    push_exp(); run_scan("unplug_a", 1'b0);
    push_exp(); run_scan("unplug_b", 1'b0);

    typ1 = 3; btn1 = 12'h818; typ2 = 2; btn2 = 12'h081;
    seen = 0;
    for (int i = 0; i < 2 * PERIOD && !seen; i++) begin
      @(negedge clk);
      if (bus.joy_split === 1'b1) seen = 1;
    end
    chk("split_rise", 32'(seen), 32'd1);
    repeat (SW + 4 * PH + 3) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_joy1", 32'(bus.joystick1), 32'h0);
    chk("midrst_joy2", 32'(bus.joystick2), 32'h0);
    chk("midrst_type1", 32'(bus.pad_type1), 32'h0);
    chk("midrst_mdsel", 32'(bus.joy_mdsel), 32'h1);
    chk("midrst_split", 32'(bus.joy_split), 32'h0);
    q.delete();
    reset_model();
    @(negedge clk);
    rst_n = 1'b1;
    push_exp();
    run_scan("post_rst", 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
